control_sequencer: RTL

//  Hardwired control unit for the Mini SRC datapath. Steps a fetch/decode/execute state machine

---
 rtl/control_sequencer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute controller for the Mini SRC datapath.
// Outputs are registered from a decode of the next state, so each strobe is valid for the
// whole cycle the machine spends in the corresponding state.
//
// state | meaning
// RST   | held in reset, every output off
// T0    | PC -> MAR, PC+1 -> Z
// T1    | Z -> PC
// T2    | instruction read, waits for mem_ready
// T3    | MDR -> IR
// E0    | operand (Rb, or base/zero for ld/ldi/st) -> Y
// E1    | ALU result -> Z
// E2    | Z -> Ra, or Z -> MAR for ld/st
// E3    | ld: data read wait / st: Ra -> MDR
// E4    | ld: MDR -> Ra / st: write wait
// HALT  | stopped by halt, unknown opcode or memory timeout; left only by reset
module control_sequencer #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        fault
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Last counter value before the wait budget is exhausted.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_E0, S_E1, S_E2, S_E3, S_E4, S_HALT
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlow_out;
    logic read;
    logic write;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic c_out;
    logic [3:0] alu;
    logic run;
  } ctl_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       timeout;
  logic       in_wait;
  ctl_t       ctl_q, ctl_d;

  logic [4:0] op;
  logic       is_rtype, is_imm, is_ldi, is_ld, is_st, is_nop;
  logic [3:0] alu_sel;
  logic       unused_ir_bits;

  assign op             = ir[31:27];
  assign unused_ir_bits = ^ir[26:0];

  assign is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_imm   = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  assign is_ldi   = (op == OP_LDI);
  assign is_ld    = (op == OP_LD);
  assign is_st    = (op == OP_ST);
  assign is_nop   = (op == OP_NOP);

  // ALU function selected by the opcode for R-type and immediate forms.
  always_comb begin
    alu_sel = ALU_ADD;
    case (op)
      OP_SUB:           alu_sel = ALU_SUB;
      OP_AND, OP_ANDI:  alu_sel = ALU_AND;
      OP_OR,  OP_ORI:   alu_sel = ALU_OR;
      default:          alu_sel = ALU_ADD;
    endcase
  end

  // Only ld and st reach E3/E4, so the st test alone picks which of them waits.
  assign in_wait = (state == S_T2) || (state == S_E3 && !is_st) || (state == S_E4 && is_st);

  // Next state plus the memory wait counter and timeout detection.
  always_comb begin
    state_nxt = state;
    wait_nxt  = 8'd0;
    timeout   = 1'b0;
    if (in_wait && !mem_ready) begin
      if (wait_cnt == WAIT_LAST) timeout = 1'b1;
      else                       wait_nxt = wait_cnt + 8'd1;
    end
    case (state)
      S_RST:  state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = S_T2;
      S_T2:   if (mem_ready) state_nxt = S_T3;
      S_T3:   state_nxt = S_E0;
      S_E0: begin
        if (is_nop)                                          state_nxt = S_T0;
        else if (is_rtype || is_imm || is_ldi || is_ld || is_st) state_nxt = S_E1;
        else                                                 state_nxt = S_HALT;
      end
      S_E1:   state_nxt = S_E2;
      S_E2:   state_nxt = (is_ld || is_st) ? S_E3 : S_T0;
      S_E3:   if (is_st || mem_ready) state_nxt = S_E4;
      S_E4:   if (!is_st || mem_ready) state_nxt = S_T0;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_HALT;
    endcase
    if (timeout) state_nxt = S_HALT;
  end

  // Strobe pattern for the state about to be entered.
  always_comb begin
    ctl_d     = '0;
    ctl_d.run = (state_nxt != S_RST) && (state_nxt != S_HALT);
    case (state_nxt)
      S_T0: begin
        ctl_d.pc_out = 1'b1; ctl_d.mar_in = 1'b1; ctl_d.inc_pc = 1'b1; ctl_d.z_in = 1'b1;
      end
      S_T1: begin
        ctl_d.zlow_out = 1'b1; ctl_d.pc_in = 1'b1;
      end
      S_T2: begin
        ctl_d.read = 1'b1; ctl_d.mdr_in = 1'b1;
      end
      S_T3: begin
        ctl_d.mdr_out = 1'b1; ctl_d.ir_in = 1'b1;
      end
      S_E0: begin
        if (is_rtype || is_imm) begin
          ctl_d.grb = 1'b1; ctl_d.r_out = 1'b1; ctl_d.y_in = 1'b1;
        end else if (is_ldi || is_ld || is_st) begin
          ctl_d.grb = 1'b1; ctl_d.ba_out = 1'b1; ctl_d.y_in = 1'b1;
        end
      end
      S_E1: begin
        ctl_d.z_in = 1'b1;
        if (is_rtype) begin
          ctl_d.grc = 1'b1; ctl_d.r_out = 1'b1; ctl_d.alu = alu_sel;
        end else if (is_imm) begin
          ctl_d.c_out = 1'b1; ctl_d.alu = alu_sel;
        end else begin
          ctl_d.c_out = 1'b1;
        end
      end
      S_E2: begin
        ctl_d.zlow_out = 1'b1;
        if (is_ld || is_st) begin
          ctl_d.mar_in = 1'b1;
        end else begin
          ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1;
        end
      end
      S_E3: begin
        ctl_d.mdr_in = 1'b1;
        if (is_st) begin
          ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1;
        end else begin
          ctl_d.read = 1'b1;
        end
      end
      S_E4: begin
        if (is_st) begin
          ctl_d.write = 1'b1;
        end else begin
          ctl_d.mdr_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1;
        end
      end
      default: ctl_d = '0;
    endcase
  end

  // State, wait counter, sticky fault and registered strobes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= S_RST;
      wait_cnt <= 8'd0;
      fault    <= 1'b0;
      ctl_q    <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      ctl_q    <= ctl_d;
      if (timeout) fault <= 1'b1;
    end
  end

  assign PCout   = ctl_q.pc_out;
  assign PCin    = ctl_q.pc_in;
  assign IncPC   = ctl_q.inc_pc;
  assign MARin   = ctl_q.mar_in;
  assign MDRin   = ctl_q.mdr_in;
  assign MDRout  = ctl_q.mdr_out;
  assign IRin    = ctl_q.ir_in;
  assign Yin     = ctl_q.y_in;
  assign Zin     = ctl_q.z_in;
  assign Zlowout = ctl_q.zlow_out;
  assign Read    = ctl_q.read;
  assign Write   = ctl_q.write;
  assign Gra     = ctl_q.gra;
  assign Grb     = ctl_q.grb;
  assign Grc     = ctl_q.grc;
  assign Rin     = ctl_q.r_in;
  assign Rout    = ctl_q.r_out;
  assign BAout   = ctl_q.ba_out;
  assign Cout    = ctl_q.c_out;
  assign alu_op  = ctl_q.alu;
  assign run     = ctl_q.run;

endmodule
